// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// One operation in flight: accept in IDLE, execute for one cycle, hold the response in DONE.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_src1,
  input  logic [DATA_W-1:0] req0_src2,
  input  logic [3:0]        req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_src1,
  input  logic [DATA_W-1:0] req1_src2,
  input  logic [3:0]        req1_ctrl,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic              alu_invertA,
  output logic              alu_invertB,
  output logic [1:0]        alu_operation,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              resp_overflow,
  output logic              busy,
  output logic [15:0]       op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_id;
  logic              accept;
  logic [DATA_W-1:0] src1_q, src2_q;
  logic [3:0]        ctrl_q;
  logic              id_q;
  logic [DATA_W-1:0] resp_result_q;
  logic              resp_zero_q, resp_ovf_q, resp_id_q;
  logic [15:0]       op_count_q;

  // On a tie the requester that was not granted last wins; a lone requester always wins.
  assign gnt_id = (req0_valid && req1_valid) ? ~last_q : req1_valid;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          accept     = 1'b1;
          last_d     = gnt_id;
          state_d    = EXEC;
        end
      end
      EXEC: state_d = DONE;
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src1_q <= '0;
      src2_q <= '0;
      ctrl_q <= '0;
      id_q   <= 1'b0;
    end else if (accept) begin
      src1_q <= gnt_id ? req1_src1 : req0_src1;
      src2_q <= gnt_id ? req1_src2 : req0_src2;
      ctrl_q <= gnt_id ? req1_ctrl : req0_ctrl;
      id_q   <= gnt_id;
    end
  end

  // ALU outputs are sampled at the end of the single EXEC cycle and then frozen through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
      resp_ovf_q    <= 1'b0;
      resp_id_q     <= 1'b0;
    end else if (state_q == EXEC) begin
      resp_result_q <= alu_result;
      resp_zero_q   <= alu_zero;
      resp_ovf_q    <= alu_overflow;
      resp_id_q     <= id_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= 16'h0000;
    end else if (state_q == DONE && resp_ready) begin
      op_count_q <= op_count_q + 16'h0001;
    end
  end

  assign alu_src1      = src1_q;
  assign alu_src2      = src2_q;
  assign alu_invertA   = ctrl_q[3];
  assign alu_invertB   = ctrl_q[2];
  assign alu_operation = ctrl_q[1:0];
  assign resp_valid    = (state_q == DONE);
  assign resp_id       = resp_id_q;
  assign resp_result   = resp_result_q;
  assign resp_zero     = resp_zero_q;
  assign resp_overflow = resp_ovf_q;
  assign busy          = (state_q != IDLE);
  assign op_count      = op_count_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; this revision supports only 32.
REQ-002 Port: clk  in  1  single clock; all state on rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: req0_valid / req1_valid  in  1  requester n has an operation pending.
REQ-005 Port: req0_ready / req1_ready  out  1  requester n's operation is accepted this cycle.
REQ-006 Port: req0_src1, req0_src2, req1_src1, req1_src2  in  DATA_W  operands of requester n.
REQ-007 Port: req0_ctrl / req1_ctrl  in  4  {invertA, invertB, operation[1:0]} of requester n.
REQ-008 Port: alu_src1, alu_src2  out  DATA_W  operands driven to the shared 32-bit ALU.
REQ-009 Port: alu_invertA, alu_invertB  out  1 each; alu_operation  out  2  ALU control.
REQ-010 Port: alu_result  in  DATA_W; alu_zero, alu_overflow  in  1 each  combinational ALU outputs.
REQ-011 Port: resp_valid  out  1; resp_ready  in  1  response handshake.
REQ-012 Port: resp_id  out  1; resp_result  out  DATA_W; resp_zero, resp_overflow  out  1 each.
REQ-013 Port: busy  out  1  high whenever state is not IDLE.
REQ-014 Port: op_count  out  16  count of completed responses.

Function
REQ-015 FSM states SHALL be IDLE, EXEC and DONE.
REQ-016 In IDLE, the block SHALL assert exactly one reqN_ready, for the granted requester, and only if that requester's valid is high; in EXEC and DONE both readys SHALL be 0.
REQ-017 Grant SHALL be round-robin: if only one requester is valid, it wins; if both are valid, the requester not granted last wins; the last-grant register SHALL reset to 1, so requester 0 wins the first tie.
REQ-018 On handshake (reqN_valid && reqN_ready), the block SHALL register src1, src2, ctrl and id=N, update last-grant to N, and enter EXEC.
REQ-019 alu_* outputs SHALL come directly from the operand/ctrl registers; they SHALL hold their last values outside EXEC.
REQ-020 At the end of the single EXEC cycle, the block SHALL capture alu_result, alu_zero and alu_overflow into resp_* and enter DONE.
REQ-021 In DONE, resp_valid SHALL be 1 and resp_* SHALL stay stable until resp_valid && resp_ready.
REQ-022 On the DONE handshake, the block SHALL go to IDLE and increment op_count; op_count SHALL wrap from 0xFFFF to 0x0000.
REQ-023 Latency SHALL be: request accepted at edge T, resp_valid high after edge T+1, earliest return to IDLE after edge T+2; peak throughput is 1 op per 3 cycles.
REQ-024 The block SHALL hold at most one operation in flight; a requester whose valid is not granted SHALL simply wait (reqN_ready=0), with no loss or reorder of its operands.
REQ-025 A requester deasserting valid before its handshake SHALL not be served; the arbiter SHALL re-evaluate every IDLE cycle.
REQ-026 The block SHALL NOT interpret ctrl; overflow and zero are passed through exactly as produced by the ALU.

Reset
REQ-027 While rst_n=0, asynchronously: state=IDLE; last-grant=1; operand/ctrl/id registers=0 (alu_* outputs 0); resp_valid=0; resp_result=0; resp_zero=0; resp_overflow=0; resp_id=0; busy=0; op_count=0.
REQ-028 Reset asserted in EXEC or DONE SHALL drop the in-flight operation without a response; after release, the first IDLE cycle SHALL arbitrate normally.

Verification
REQ-029 Single request: req0 add (ctrl=0010) 5+7, resp_ready=1 -> req0_ready in cycle 0, resp_valid at cycle 2 with result=12, zero=0, id=0, op_count=1.
REQ-030 Tie after reset: both valid continuously, resp_ready=1 -> grants alternate 0,1,0,1 and resp_id follows the same order; each request is held until it is served.
REQ-031 Backpressure: resp_ready=0 for 5 cycles in DONE -> resp_* stable, both readys 0, busy=1; op_count increments only on the release cycle.
REQ-032 Subtract to zero: req1 ctrl=0110 with src1=src2=0x1234 -> resp_result=0, resp_zero=1, id=1.
REQ-033 Reset mid-EXEC: rst_n low during EXEC -> resp_valid never rises, op_count=0, next tie grants requester 0.
REQ-034 op_count wrap: preload op_count to 0xFFFF via 65535 ops (or force), complete one more op -> op_count=0x0000.
